window_controller: RTL and testbench

- Sits between the pixel source (DMA/stream) and the Sobel convolution stage; owns four line_buffer instances.
- Writes incoming pixels round-robin into the four line buffers, one row each.
- Once three full rows are stored, reads three buffers in lockstep and emits one 3x3 window (72 bits) per cycle.
- Raises a one-cycle interrupt after each consumed row so the source can send the next row.

---
 rtl/window_controller_pkg.sv | 22 ++
 rtl/window_controller_if.sv | 37 +++
 rtl/window_controller_line_buffer.sv | 53 +++++
 rtl/window_controller.sv | 152 +++++++++++++++
 tb/tb_window_controller.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/window_controller_pkg.sv
// Shared definitions for the 3x3 window controller.
//   NUM_LB              : number of line buffers in the ring (fixed at 4)
//   WINDOW_W            : width of one 3x3 window of 8-bit pixels
//   PIXEL_W             : width of one pixel
//   DEFAULT_IMAGE_WIDTH : default pixels per row
//   win_state_t         : read-side FSM states
//   lb_idx_t            : index of one line buffer in the ring (wraps mod 4)
package window_controller_pkg;

  localparam int NUM_LB              = 4;
  localparam int PIXEL_W             = 8;
  localparam int WINDOW_W            = 9 * PIXEL_W;
  localparam int DEFAULT_IMAGE_WIDTH = 512;

  typedef enum logic {
    IDLE,
    READ
  } win_state_t;

  typedef logic [1:0] lb_idx_t;

endpackage

// File: rtl/window_controller_if.sv
// Pixel-stream interface between the pixel source and the window controller.
//   i_pixel_data       : incoming pixel
//   i_pixel_data_valid : one pixel per asserted cycle
//   o_pixel_data       : 3x3 window, oldest row in MSBs, leftmost pixel first
//   o_pixel_data_valid : window qualifier
//   o_intr             : one-cycle pulse after a row has been consumed
//   o_overflow         : sticky, a pixel was dropped because the ring was full
// master = pixel source / window consumer, slave = window_controller.
interface window_controller_if;
  import window_controller_pkg::*;

  logic [PIXEL_W-1:0]  i_pixel_data;
  logic                i_pixel_data_valid;
  logic [WINDOW_W-1:0] o_pixel_data;
  logic                o_pixel_data_valid;
  logic                o_intr;
  logic                o_overflow;

  modport master (
    output i_pixel_data,
    output i_pixel_data_valid,
    input  o_pixel_data,
    input  o_pixel_data_valid,
    input  o_intr,
    input  o_overflow
  );

  modport slave (
    input  i_pixel_data,
    input  i_pixel_data_valid,
    output o_pixel_data,
    output o_pixel_data_valid,
    output o_intr,
    output o_overflow
  );

endinterface

// File: rtl/window_controller_line_buffer.sv
// One row of pixel storage.
//   clk          : rising-edge clock
//   i_rst_n      : synchronous active-low reset (pointers only)
//   i_data       : pixel to store
//   i_data_valid : store i_data at the write pointer, advance it
//   o_data       : {p[rd], p[rd+1], p[rd+2]} read combinationally; indices
//                  wrap, so the last two reads of a row return stale pixels
//   i_rd_data    : advance the read pointer
module window_controller_line_buffer
  import window_controller_pkg::*;
#(
  parameter int IMAGE_WIDTH = DEFAULT_IMAGE_WIDTH
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  input  logic [PIXEL_W-1:0]   i_data,
  input  logic                 i_data_valid,
  output logic [3*PIXEL_W-1:0] o_data,
  input  logic                 i_rd_data
);

  localparam int PTR_W = $clog2(IMAGE_WIDTH);

  logic [PIXEL_W-1:0] mem [IMAGE_WIDTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_p1;
  logic [PTR_W-1:0]   rd_ptr_p2;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(IMAGE_WIDTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (i_data_valid) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (i_rd_data)    rd_ptr_reg <= ptr_inc(rd_ptr_reg);
    end
  end

  // Storage carries no reset; stale contents are never exposed as valid.
  always_ff @(posedge clk) begin
    if (i_data_valid) mem[wr_ptr_reg] <= i_data;
  end

  assign rd_ptr_p1 = ptr_inc(rd_ptr_reg);
  assign rd_ptr_p2 = ptr_inc(rd_ptr_p1);
  assign o_data    = {mem[rd_ptr_reg], mem[rd_ptr_p1], mem[rd_ptr_p2]};

endmodule

// File: rtl/window_controller.sv
// Ring of four line buffers turning a pixel stream into 3x3 windows.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : window_controller_if.slave (pixel in, window/intr/overflow out)
// Rows are written round-robin into the ring. Once three full rows are
// held, three consecutive buffers are read in lockstep for one row period
// (IMAGE_WIDTH reads, IMAGE_WIDTH-2 valid windows), then the oldest row is
// released and o_intr pulses. The fourth buffer may fill during the read.
module window_controller
  import window_controller_pkg::*;
#(
  parameter int IMAGE_WIDTH = DEFAULT_IMAGE_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  window_controller_if.slave  bus
);

  localparam int CNT_W = $clog2(NUM_LB * IMAGE_WIDTH + 1);
  localparam int COL_W = $clog2(IMAGE_WIDTH);

  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(NUM_LB * IMAGE_WIDTH);
  localparam logic [CNT_W-1:0] READY_CNT = CNT_W'(3 * IMAGE_WIDTH);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [COL_W-1:0] LAST_WIN  = COL_W'(IMAGE_WIDTH - 3);

  win_state_t          state_reg, state_next;
  logic [COL_W-1:0]    wr_col_reg;
  lb_idx_t             wr_lb_reg;
  logic [COL_W-1:0]    rd_col_reg;
  lb_idx_t             rd_lb_reg;
  logic [CNT_W-1:0]    pix_cnt_reg;
  logic                overflow_reg;
  logic                intr_reg;
  logic [WINDOW_W-1:0] out_data_reg;
  logic                out_valid_reg;

  logic                rd_en;
  logic                rd_last;
  logic                wr_accept;
  logic                rst_n;
  logic [WINDOW_W-1:0] window_mux;

  logic [3*PIXEL_W-1:0] lb_data [NUM_LB];
  logic [NUM_LB-1:0]    lb_wr_valid;
  logic [NUM_LB-1:0]    lb_rd;

  assign rst_n = ~rst;

  // A pixel is dropped only when the ring is full and nothing is draining
  // this cycle; a concurrent read frees exactly the slot being written.
  assign wr_accept = bus.i_pixel_data_valid &&
                     !((pix_cnt_reg == FULL_CNT) && !rd_en);
  assign rd_last   = rd_en && (rd_col_reg == LAST_COL);

  always_comb begin
    state_next = state_reg;
    rd_en      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pix_cnt_reg >= READY_CNT) state_next = READ;
      end
      READ: begin
        rd_en = 1'b1;
        if (rd_col_reg == LAST_COL) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      wr_col_reg    <= '0;
      wr_lb_reg     <= '0;
      rd_col_reg    <= '0;
      rd_lb_reg     <= '0;
      pix_cnt_reg   <= '0;
      overflow_reg  <= 1'b0;
      intr_reg      <= 1'b0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (wr_accept) begin
        if (wr_col_reg == LAST_COL) begin
          wr_col_reg <= '0;
          wr_lb_reg  <= wr_lb_reg + 2'd1;
        end else begin
          wr_col_reg <= wr_col_reg + 1'b1;
        end
      end

      case ({wr_accept, rd_en})
        2'b10:   pix_cnt_reg <= pix_cnt_reg + CNT_W'(1);
        2'b01:   pix_cnt_reg <= pix_cnt_reg - CNT_W'(1);
        default: pix_cnt_reg <= pix_cnt_reg;
      endcase

      if (bus.i_pixel_data_valid && !wr_accept) overflow_reg <= 1'b1;

      if (rd_en) begin
        rd_col_reg <= rd_last ? '0 : rd_col_reg + 1'b1;
        if (rd_last) rd_lb_reg <= rd_lb_reg + 2'd1;
      end

      intr_reg      <= rd_last;
      // Last two reads of a row only realign the buffer read pointers.
      out_valid_reg <= rd_en && (rd_col_reg <= LAST_WIN);
      if (rd_en) out_data_reg <= window_mux;
    end
  end

  // Oldest row (rd_lb) lands in the MSBs.
  always_comb begin
    lb_idx_t idx0, idx1, idx2;
    idx0       = rd_lb_reg;
    idx1       = rd_lb_reg + 2'd1;
    idx2       = rd_lb_reg + 2'd2;
    window_mux = {lb_data[idx0], lb_data[idx1], lb_data[idx2]};
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LB; gi++) begin : g_lb
      lb_idx_t ring_dist;
      // Distance of this buffer behind the oldest row; distance 3 is the
      // buffer currently being filled and is not part of the window.
      assign ring_dist       = lb_idx_t'(gi) - rd_lb_reg;
      assign lb_wr_valid[gi] = wr_accept && (wr_lb_reg == lb_idx_t'(gi));
      assign lb_rd[gi]       = rd_en && (ring_dist != 2'd3);

      window_controller_line_buffer #(
        .IMAGE_WIDTH (IMAGE_WIDTH)
      ) u_lb (
        .clk          (clk),
        .i_rst_n      (rst_n),
        .i_data       (bus.i_pixel_data),
        .i_data_valid (lb_wr_valid[gi]),
        .o_data       (lb_data[gi]),
        .i_rd_data    (lb_rd[gi])
      );
    end
  endgenerate

  assign bus.o_pixel_data       = out_data_reg;
  assign bus.o_pixel_data_valid = out_valid_reg;
  assign bus.o_intr             = intr_reg;
  assign bus.o_overflow         = overflow_reg;

endmodule

// File: tb/tb_window_controller.sv
// Bench for window_controller with IMAGE_WIDTH=8. The reference model keeps
// every accepted row in a queue; whenever a row completes and at least three
// rows exist, the IMAGE_WIDTH-2 windows of the newest triple are queued as
// expected output. A negedge monitor compares every valid window in order.
module tb_window_controller;

  localparam int W = 8;

  logic clk;
  logic rst;

  window_controller_if bus ();

  window_controller #(
    .IMAGE_WIDTH (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [8*W-1:0] rows_q[$];
  logic [71:0]    exp_q[$];
  logic [8*W-1:0] cur_row;
  int             col;
  int             accepted;
  int             intr_cnt;
  int             win_cnt;
  bit             sb_en;
  bit             intr_prev;

  function automatic logic [23:0] row_slice(input logic [8*W-1:0] r, input int c);
    return {r[8*c +: 8], r[8*(c+1) +: 8], r[8*(c+2) +: 8]};
  endfunction

  task automatic model_accept(input logic [7:0] d);
    cur_row[8*col +: 8] = d;
    col++;
    accepted++;
    if (col == W) begin
      rows_q.push_back(cur_row);
      col = 0;
      if (rows_q.size() >= 3) begin
        int t;
        t = rows_q.size() - 3;
        for (int c = 0; c < W - 2; c++)
          exp_q.push_back({row_slice(rows_q[t], c), row_slice(rows_q[t+1], c),
                           row_slice(rows_q[t+2], c)});
      end
    end
  endtask

  task automatic model_clear();
    rows_q.delete();
    exp_q.delete();
    cur_row  = '0;
    col      = 0;
    accepted = 0;
    intr_cnt = 0;
    win_cnt  = 0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_intr) begin
        check("intr_pulse_width", intr_prev, 1'b0);
        intr_cnt++;
      end
      intr_prev = bus.o_intr;
      if (sb_en && bus.o_pixel_data_valid) begin
        if (exp_q.size() == 0) begin
          check("window_unexpected", 1'b1, 1'b0);
        end else begin
          logic [71:0] e;
          e = exp_q.pop_front();
          check("window", bus.o_pixel_data, e);
          $display("window %0d data=%h exp=%h", win_cnt, bus.o_pixel_data, e);
          win_cnt++;
        end
      end
    end else begin
      intr_prev = 1'b0;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic do_reset(input int ncyc);
    rst = 1'b1;
    bus.i_pixel_data_valid = 1'b0;
    repeat (ncyc) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic push_pixel(input logic [7:0] d);
    bus.i_pixel_data       = d;
    bus.i_pixel_data_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.i_pixel_data_valid = 1'b0;
    if (sb_en) model_accept(d);
  endtask

  task automatic idle_cycles(input int n);
    bus.i_pixel_data_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Source-side flow control: never hold more than four rows unconsumed.
  task automatic wait_room();
    int n;
    n = 0;
    while ((accepted - W * intr_cnt >= 4 * W) && n < 500) begin
      idle_cycles(1);
      n++;
    end
    if (n >= 500) check("wait_room_timeout", 1'b1, 1'b0);
  endtask

  task automatic wait_drain();
    int n;
    int exp_intr;
    exp_intr = (rows_q.size() >= 2) ? rows_q.size() - 2 : 0;
    n = 0;
    while ((exp_q.size() != 0 || intr_cnt < exp_intr) && n < 3000) begin
      idle_cycles(1);
      n++;
    end
    if (n >= 3000) check("drain_timeout", 1'b1, 1'b0);
    idle_cycles(3);
    check("intr_count", intr_cnt, exp_intr);
  endtask

  task automatic push_row_pattern(input int r);
    for (int c = 0; c < W; c++) push_pixel(8'(16 * r + c));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_pixel_data       = '0;
    bus.i_pixel_data_valid = 1'b0;
    rst       = 1'b1;
    sb_en     = 1'b1;
    intr_prev = 1'b0;
    model_clear();

    // Reset state
    do_reset(2);
    check("rst_data",  bus.o_pixel_data, 72'h0);
    check("rst_valid", bus.o_pixel_data_valid, 1'b0);
    check("rst_intr",  bus.o_intr, 1'b0);
    check("rst_ovf",   bus.o_overflow, 1'b0);

    // Rows 0-1: nothing may come out
    push_row_pattern(0);
    push_row_pattern(1);
    idle_cycles(5);
    check("two_rows_no_window", win_cnt, 0);
    check("two_rows_no_intr",   intr_cnt, 0);

    // Row 2: exact latency of the first window
    push_row_pattern(2);
    @(posedge clk); #1;
    check("first_win_not_early", bus.o_pixel_data_valid, 1'b0);
    @(posedge clk); #1;
    check("first_win_valid", bus.o_pixel_data_valid, 1'b1);
    check("first_win_data",  bus.o_pixel_data, 72'h000102_101112_202122);

    // Row 3 written while the first triple is being read
    push_row_pattern(3);
    wait_drain();
    check("win_count_after_row3", win_cnt, 2 * (W - 2));

    // Rows 4-7 with flow control; exercises rd_lb wrap 3->0
    for (int r = 4; r < 8; r++) begin
      for (int c = 0; c < W; c++) begin
        wait_room();
        push_pixel(8'(16 * r + c));
      end
    end
    wait_drain();
    check("ovf_after_flow", bus.o_overflow, 1'b0);

    // Randomized rows, random gaps, flow-controlled
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < W; c++) begin
        wait_room();
        if ($urandom_range(3) == 0) idle_cycles($urandom_range(1, 3));
        push_pixel(8'($urandom));
      end
    end
    wait_drain();
    check("ovf_after_random", bus.o_overflow, 1'b0);

    // Overflow: 128 pixels back-to-back ignoring o_intr
    do_reset(2);
    sb_en = 1'b0;
    begin
      bit seen_set;
      bit dropped_after_set;
      seen_set          = 1'b0;
      dropped_after_set = 1'b0;
      for (int i = 0; i < 128; i++) begin
        push_pixel(8'(i));
        if (bus.o_overflow) seen_set = 1'b1;
        else if (seen_set)  dropped_after_set = 1'b1;
      end
      check("ovf_set_during_stream", seen_set, 1'b1);
      check("ovf_sticky_stream", dropped_after_set, 1'b0);
    end
    idle_cycles(20);
    check("ovf_sticky_idle", bus.o_overflow, 1'b1);
    do_reset(1);
    check("ovf_cleared_by_rst", bus.o_overflow, 1'b0);
    sb_en = 1'b1;

    // Reset in the middle of READ discards every stored row
    do_reset(2);
    push_row_pattern(0);
    push_row_pattern(1);
    push_row_pattern(2);
    begin
      int seen;
      int n;
      seen = 0;
      n    = 0;
      while (seen < 3 && n < 200) begin
        @(negedge clk);
        n++;
        if (bus.o_pixel_data_valid) seen++;
      end
      check("midread_third_beat_seen", seen, 3);
    end
    do_reset(1);
    check("midread_rst_data",  bus.o_pixel_data, 72'h0);
    check("midread_rst_valid", bus.o_pixel_data_valid, 1'b0);
    check("midread_rst_intr",  bus.o_intr, 1'b0);
    for (int i = 0; i < 23; i++) push_pixel(8'(16 * (i / W) + (i % W)));
    idle_cycles(4);
    check("midread_23_no_window", win_cnt, 0);
    check("midread_23_valid",     bus.o_pixel_data_valid, 1'b0);
    push_pixel(8'h27);
    @(posedge clk); #1;
    check("midread_24_not_early", bus.o_pixel_data_valid, 1'b0);
    @(posedge clk); #1;
    check("midread_24_valid", bus.o_pixel_data_valid, 1'b1);
    check("midread_24_data",  bus.o_pixel_data, 72'h000102_101112_202122);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
